// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode 7-segment scanner with frame-synchronous double buffering.
// Optional leading-zero suppression is enabled by defining LZ_SUPPRESS_EN.
module seg_scan_ctrl #(
  parameter int DIGITS    = 6,
  parameter int SCAN_LOG2 = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                load_i,
  input  logic [5*DIGITS-1:0] digit_data_i,
  input  logic [DIGITS-1:0]   blank_mask_i,
  input  logic [3:0]          bright_i,
  output logic [7:0]          seg_out_o,
  output logic [DIGITS-1:0]   sel_out_o,
  output logic                frame_done_o
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SCAN_LOG2-1:0] PRE_MAX = '1;
  localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(DIGITS - 1);

  logic [SCAN_LOG2-1:0] pre_q, pre_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [5*DIGITS-1:0]  act_data_q, act_data_d;
  logic [5*DIGITS-1:0]  pend_data_q, pend_data_d;
  logic [DIGITS-1:0]    act_blank_q, act_blank_d;
  logic [DIGITS-1:0]    pend_blank_q, pend_blank_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [7:0]           seg_q, seg_d;
  logic [DIGITS-1:0]    sel_q, sel_d;
  logic                 frame_done_q, frame_done_d;
  logic                 boundary;
  logic                 lit;
  logic [DIGITS-1:0]    lz_mask;
  logic [3:0]           hex_a [DIGITS];
  logic                 dp_a  [DIGITS];

  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    case (h)
      4'h0:    seg_decode = 7'h40;
      4'h1:    seg_decode = 7'h79;
      4'h2:    seg_decode = 7'h24;
      4'h3:    seg_decode = 7'h30;
      4'h4:    seg_decode = 7'h19;
      4'h5:    seg_decode = 7'h12;
      4'h6:    seg_decode = 7'h02;
      4'h7:    seg_decode = 7'h78;
      4'h8:    seg_decode = 7'h00;
      4'h9:    seg_decode = 7'h10;
      4'hA:    seg_decode = 7'h08;
      4'hB:    seg_decode = 7'h03;
      4'hC:    seg_decode = 7'h46;
      4'hD:    seg_decode = 7'h21;
      4'hE:    seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_unpack
    assign hex_a[gi] = act_data_q[5*gi +: 4];
    assign dp_a[gi]  = act_data_q[5*gi + 4];
  end

  assign boundary = (pre_q == PRE_MAX) && (idx_q == IDX_MAX);

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_MAX) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    frame_done_d = (pre_d == PRE_MAX) && (idx_d == IDX_MAX);
  end

  // A load coinciding with the boundary bypasses pending and goes straight to active.
  always_comb begin
    act_data_d   = act_data_q;
    act_blank_d  = act_blank_q;
    pend_data_d  = pend_data_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    if (boundary) begin
      pend_valid_d = 1'b0;
      if (load_i) begin
        act_data_d  = digit_data_i;
        act_blank_d = blank_mask_i;
      end else if (pend_valid_q) begin
        act_data_d  = pend_data_q;
        act_blank_d = pend_blank_q;
      end
    end else if (load_i) begin
      pend_data_d  = digit_data_i;
      pend_blank_d = blank_mask_i;
      pend_valid_d = 1'b1;
    end
  end

`ifdef LZ_SUPPRESS_EN
  // Walk down from the top digit; suppression stops at the first non-blank-looking digit.
  always_comb begin
    logic still_zero;
    lz_mask    = '0;
    still_zero = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      still_zero = still_zero && (act_data_q[5*d +: 5] == 5'd0);
      lz_mask[d] = still_zero;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    lit   = (pre_q[SCAN_LOG2-1 -: 4] <= bright_i);
    seg_d = 8'hFF;
    sel_d = '1;
    if (lit && !act_blank_q[idx_q] && !lz_mask[idx_q]) begin
      sel_d[idx_q] = 1'b0;
      seg_d        = {~dp_a[idx_q], seg_decode(hex_a[idx_q])};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_blank_q  <= '0;
      pend_data_q  <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= 8'hFF;
      sel_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_blank_q  <= act_blank_d;
      pend_data_q  <= pend_data_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out_o    = seg_q;
  assign sel_out_o    = sel_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (DIGITS=6, SCAN_LOG2=4); a cycle-count
// reference model queues the expected output of every clock and scenario tasks add targeted checks.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
  localparam int D     = 6;
  localparam int SL    = 4;
  localparam int SLOT  = 16;
  localparam int FRAME = D * SLOT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [5*D-1:0] digit_data;
  logic [D-1:0]  blank_mask;
  logic [3:0]    bright;
  logic [7:0]    seg_out;
  logic [D-1:0]  sel_out;
  logic          frame_done;

  seg_scan_ctrl #(.DIGITS(D), .SCAN_LOG2(SL)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .load_i       (load),
    .digit_data_i (digit_data),
    .blank_mask_i (blank_mask),
    .bright_i     (bright),
    .seg_out_o    (seg_out),
    .sel_out_o    (sel_out),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  seg;
    logic [D-1:0] sel;
    logic        fd;
    logic [31:0] at;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cnt = 0;
  logic [5*D-1:0] m_act_data, m_pend_data;
  logic [D-1:0]   m_act_blank, m_pend_blank;
  logic           m_pv;

  function automatic logic [6:0] ref_dec(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[h];
  endfunction

  function automatic logic [5*D-1:0] rep(input logic [3:0] h, input logic dp);
    logic [4:0] v;
    v = {dp, h};
    return {D{v}};
  endfunction

  task automatic model_reset();
    cnt = 0;
    m_act_data = '0; m_pend_data = '0;
    m_act_blank = '0; m_pend_blank = '0;
    m_pv = 1'b0;
    q.delete();
  endtask

  // One clock: predict the registered outputs, advance the model, then compare.
  task automatic step();
    int pre, idx;
    bit supp;
    exp_t e;
    pre = cnt % SLOT;
    idx = (cnt / SLOT) % D;
    supp = 1'b0;
`ifdef LZ_SUPPRESS_EN
    if (idx != 0) begin
      supp = 1'b1;
      for (int d = idx; d < D; d++) if (m_act_data[5*d +: 5] != 5'd0) supp = 1'b0;
    end
`endif
    e.seg = 8'hFF;
    e.sel = '1;
    if (pre <= int'(bright) && !m_act_blank[idx] && !supp) begin
      e.sel[idx] = 1'b0;
      e.seg = {~m_act_data[5*idx+4], ref_dec(m_act_data[5*idx +: 4])};
    end
    e.fd = (((cnt + 1) % FRAME) == FRAME - 1);
    e.at = 32'(cnt + 1);
    q.push_back(e);
    @(posedge clk);
    if (cnt % FRAME == FRAME - 1) begin
      if (load) begin
        m_act_data = digit_data; m_act_blank = blank_mask;
      end else if (m_pv) begin
        m_act_data = m_pend_data; m_act_blank = m_pend_blank;
      end
      m_pv = 1'b0;
    end else if (load) begin
      m_pend_data = digit_data; m_pend_blank = blank_mask; m_pv = 1'b1;
    end
    cnt++;
    #1;
    e = q.pop_front();
    checks++;
    if (seg_out !== e.seg) begin
      errors++;
      $display("FAIL seg_out cyc=%0d got=%02h exp=%02h", e.at, seg_out, e.seg);
    end
    checks++;
    if (sel_out !== e.sel) begin
      errors++;
      $display("FAIL sel_out cyc=%0d got=%b exp=%b", e.at, sel_out, e.sel);
    end
    checks++;
    if (frame_done !== e.fd) begin
      errors++;
      $display("FAIL frame_done cyc=%0d got=%b exp=%b", e.at, frame_done, e.fd);
    end
  endtask

  task automatic step_to(input int m);
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (cnt % FRAME == m) break;
    end
  endtask

  task automatic do_load(input logic [5*D-1:0] data, input logic [D-1:0] blank);
    load = 1'b1; digit_data = data; blank_mask = blank;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    int first_fd;
    first_fd = -1;
    rst_n = 1'b0; load = 1'b0; digit_data = '0; blank_mask = '0; bright = 4'd15;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (seg_out !== 8'hFF || sel_out !== 6'h3F || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got=%02h/%b/%b exp=ff/111111/0", seg_out, sel_out, frame_done);
    end
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + 2; i++) begin
      step();
      if (cnt == 1) begin
        checks++;
        if (seg_out !== 8'hC0 || sel_out !== 6'b111110) begin
          errors++;
          $display("FAIL first_digit got=%02h/%b exp=c0/111110", seg_out, sel_out);
        end
      end
      if (cnt == 17) begin
        checks++;
`ifdef LZ_SUPPRESS_EN
        if (sel_out !== 6'b111111) begin
          errors++;
          $display("FAIL second_slot_sel got=%b exp=111111", sel_out);
        end
`else
        if (sel_out !== 6'b111101) begin
          errors++;
          $display("FAIL second_slot_sel got=%b exp=111101", sel_out);
        end
`endif
      end
      if (frame_done && first_fd < 0) first_fd = cnt;
    end
    checks++;
    if (first_fd != 95) begin
      errors++;
      $display("FAIL first_frame_done got=%0d exp=95", first_fd);
    end
  endtask

  task automatic test_load();
    step_to(10);
    do_load({5'h0F, 5'h0E, 5'h03, 5'h02, 5'h01, 5'h00}, '0);
    step_to(81);
    checks++;
    if (seg_out !== 8'hC0 || sel_out !== 6'b011111) begin
      errors++;
      $display("FAIL old_data_persists got=%02h/%b exp=c0/011111", seg_out, sel_out);
    end
    step_to(0);
    checks++;
    if (seg_out !== 8'hC0 || sel_out !== 6'b011111) begin
      errors++;
      $display("FAIL boundary_plus1_old got=%02h/%b exp=c0/011111", seg_out, sel_out);
    end
    step_to(49);
    checks++;
    if (seg_out !== 8'hB0 || sel_out !== 6'b110111) begin
      errors++;
      $display("FAIL digit3_new got=%02h/%b exp=b0/110111", seg_out, sel_out);
    end
    step_to(81);
    checks++;
    if (seg_out !== 8'h8E || sel_out !== 6'b011111) begin
      errors++;
      $display("FAIL digit5_new got=%02h/%b exp=8e/011111", seg_out, sel_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [D-1:0] exp_sel;
    step_to(20);
    do_load(rep(4'h1, 1'b0), '0);
    step_to(40);
    do_load(rep(4'h7, 1'b0), '0);
    step_to(95);
    do_load(rep(4'h9, 1'b0), '0);
    for (int k = 0; k < D; k++) begin
      step_to(k * SLOT + 9);
      exp_sel = '1;
      exp_sel[k] = 1'b0;
      checks++;
      if (seg_out !== 8'h90 || sel_out !== exp_sel) begin
        errors++;
        $display("FAIL boundary_load_digit%0d got=%02h/%b exp=90/%b", k, seg_out, sel_out, exp_sel);
      end
    end
  endtask

  task automatic test_brightness();
    int lit;
    int levels [3];
    levels = '{0, 7, 15};
    for (int j = 0; j < 3; j++) begin
      bright = 4'(levels[j]);
      lit = 0;
      for (int i = 0; i < SLOT; i++) begin
        step();
        if (sel_out !== 6'h3F) lit++;
      end
      checks++;
      if (lit != levels[j] + 1) begin
        errors++;
        $display("FAIL duty_bright%0d got=%0d exp=%0d", levels[j], lit, levels[j] + 1);
      end
    end
    bright = 4'd15;
  endtask

  task automatic test_blank();
    int low2, low1;
    low2 = 0; low1 = 0;
    do_load(rep(4'h9, 1'b0), 6'b000100);
    step_to(0);
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (sel_out[2] === 1'b0) low2++;
      if (sel_out[1] === 1'b0) low1++;
    end
    checks++;
    if (low2 != 0) begin
      errors++;
      $display("FAIL blank_digit2 got=%0d exp=0", low2);
    end
    checks++;
    if (low1 != SLOT) begin
      errors++;
      $display("FAIL unblanked_digit1 got=%0d exp=%0d", low1, SLOT);
    end
  endtask

`ifdef LZ_SUPPRESS_EN
  task automatic lz_case(input logic [5*D-1:0] data, input logic [D-1:0] exp_lit,
                         input int probe, input logic [7:0] exp_seg);
    logic [D-1:0] lit_mask;
    logic [7:0]   probe_seg;
    lit_mask = '0;
    probe_seg = 8'hFF;
    do_load(data, '0);
    step_to(0);
    for (int i = 0; i < FRAME; i++) begin
      step();
      lit_mask |= ~sel_out;
      if (sel_out[probe] === 1'b0) probe_seg = seg_out;
    end
    checks++;
    if (lit_mask !== exp_lit) begin
      errors++;
      $display("FAIL lz_lit_mask got=%b exp=%b", lit_mask, exp_lit);
    end
    checks++;
    if (probe_seg !== exp_seg) begin
      errors++;
      $display("FAIL lz_digit%0d got=%02h exp=%02h", probe, probe_seg, exp_seg);
    end
  endtask

  task automatic test_lz();
    lz_case({5'h00, 5'h00, 5'h00, 5'h04, 5'h00, 5'h00}, 6'b000111, 2, 8'h99);
    lz_case({5'h00, 5'h10, 5'h00, 5'h04, 5'h00, 5'h00}, 6'b011111, 4, 8'h40);
    lz_case('0, 6'b000001, 0, 8'hC0);
  endtask
`endif

  task automatic test_reset_mid();
    int seen_new, seen_zero;
    seen_new = 0; seen_zero = 0;
    step_to(30);
    do_load(rep(4'h5, 1'b0), '0);
    step_to(39);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg_out !== 8'hFF || sel_out !== 6'h3F || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got=%02h/%b/%b exp=ff/111111/0", seg_out, sel_out, frame_done);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (seg_out !== 8'hFF || sel_out !== 6'h3F) begin
      errors++;
      $display("FAIL reset_hold got=%02h/%b exp=ff/111111", seg_out, sel_out);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (seg_out === 8'h92) seen_new++;
      if (seg_out === 8'hC0) seen_zero++;
    end
    checks++;
    if (seen_new != 0) begin
      errors++;
      $display("FAIL discarded_pending got=%0d exp=0", seen_new);
    end
    checks++;
    if (seen_zero == 0) begin
      errors++;
      $display("FAIL zeros_after_reset got=%0d exp=nonzero", seen_zero);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_brightness();
    test_blank();
`ifdef LZ_SUPPRESS_EN
    test_lz();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed 7-segment scan controller for common-anode displays with active-low digit selects. It drives DIGITS digits from a double-buffered display register and applies updates only at frame boundaries, so digits never tear. It also provides per-digit blanking, 16-level PWM brightness and a frame-complete strobe. It sits between the UART command/decoder logic and the board's segment and select pins.

## Interface
- DIGITS, 6: number of digits scanned (2..8).
- SCAN_LOG2, 16: log2 of clock cycles per digit slot (≥4).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle request to capture digit_data/blank_mask.
- digit_data  in  5*DIGITS  per digit d: bits [5d+3:5d] = hex value, bit [5d+4] = decimal point on.
- blank_mask  in  DIGITS  1 = digit d dark.
- bright  in  4  brightness, 0 (1/16 duty) .. 15 (full).
- seg_out  out  8  active-low segments; [6:0]=gfedcba, [7]=DP.
- sel_out  out  DIGITS  active-low digit select, at most one bit low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Prescaler pre, SCAN_LOG2 bits, free-running, wraps 2^SCAN_LOG2−1 → 0. Digit index idx advances on pre wrap; idx wraps DIGITS−1 → 0. Frame boundary = pre at terminal count and idx = DIGITS−1.
- Buffers: active and pending, each holding data plus blank_mask, and a pending_valid flag.
- load outside a boundary: pending ← inputs, pending_valid ← 1. A second load before the boundary overwrites pending; the last write wins.
- At the boundary:
  - if load is also high, active ← inputs (input wins);
  - else if pending_valid, active ← pending;
  - in both cases pending_valid ← 0.
- frame_done pulses on the boundary cycle.
- PWM phase = pre[SCAN_LOG2-1:SCAN_LOG2-4]. The digit is lit when phase ≤ bright. bright is sampled live, with no buffering.
- Digit idx is driven if it is lit and not blanked (and not suppressed, see Configuration). Driven: sel_out[idx]=0, all other select bits 1. Otherwise sel_out is all ones and seg_out = 8'hFF.
- Decode, active-low: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex, 7-bit). seg_out[7] = ~dp.

## Timing
- Reset values: pre=0, idx=0, active and pending buffers all zero, pending_valid=0. Outputs: seg_out=8'hFF, sel_out all ones, frame_done=0.
- seg_out and sel_out are registered and lag pre/idx by exactly 1 clock. No combinational path from any input to any output.
- Slot = 2^SCAN_LOG2 cycles. Frame = DIGITS·2^SCAN_LOG2 cycles.
- After rst deasserts, the first frame_done occurs on cycle DIGITS·2^SCAN_LOG2 − 1, counted from the first active clock as cycle 0.
- Load-to-visible latency: newly loaded data appears on outputs 2 cycles after the boundary that commits it (1 cycle commit, 1 cycle output register). Worst case is one frame plus 2 cycles.
- Reset mid-frame: everything returns immediately to reset values and pending data is discarded.

## Configuration
- LZ_SUPPRESS_EN defined: leading-zero suppression on the active buffer. Scanning from digit DIGITS−1 downward, each digit with hex=0, dp=0 is treated as blanked until the first digit that fails that test. Digit 0 is never suppressed.
- Undefined: all non-masked digits display, zeros included. No suppression logic is synthesised.

## Test plan
All scenarios use DIGITS=6, SCAN_LOG2=4.
- Reset release, no load → sel_out cycles 111110, 111101, … every 16 cycles, seg_out=40 (digit "0", DP off = 8'hC0). frame_done first pulses at cycle 95, then every 96 cycles.
- load with digits 5..0 = F,E,3,2,1,0 at cycle 10 → old zeros persist to the frame end. From the boundary+2, digit 5 shows 8'h8E and digit 3 shows 8'hB0.
- Two loads in one frame (values 1 then 7 in all digits), plus a load of 9 on the boundary cycle → the next frame shows 9 on all digits (8'h90).
- bright=0 → sel active for 1 of 16 cycles per slot. bright=7 → 8 of 16 cycles. bright=15 → 16 of 16 cycles. blank_mask=6'b000100 → digit 2 select never low.
- With LZ_SUPPRESS_EN and digits 0,0,0,4,0,0 loaded (digit 5 first) → digits 5–3 dark, digits 2..0 show 4,0,0. With digit 4 dp=1 → digit 4 shows 8'h40, only digit 5 dark. All zeros → only digit 0 lit.
- rst asserted mid-slot with pending_valid=1 → outputs go to 8'hFF / all ones within the same cycle. After release, display shows zeros and the discarded pending data never appears.
